// File: rtl/idann_pkg.sv
// Shared widths, reset weights, FSM encoding and saturation helpers for the
// output-layer backward-pass stage.
package idann_pkg;

   localparam int N_HID      = 8;
   localparam int X_WIDTH    = 10;
   localparam int Y_WIDTH    = 23;
   localparam int T_WIDTH    = 10;
   localparam int ERR_WIDTH  = 12;
   localparam int W_WIDTH    = 8;
   localparam int LR_SHIFT   = 4;
   localparam int IDX_WIDTH  = 3;
   localparam int DIFF_WIDTH = 24;

   // w0 sits in the least-significant byte
   localparam logic [N_HID*W_WIDTH-1:0] INIT_OW =
      {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

   typedef enum logic [1:0] {IDLE, CAPTURE, UPDATE, DONE} state_t;

   function automatic logic signed [ERR_WIDTH-1:0] sat_err(input logic signed [DIFF_WIDTH-1:0] d);
      if (d > 24'sd2047)
         return 12'h7FF;
      else if (d < -24'sd2048)
         return 12'h800;
      else
         return $signed(d[ERR_WIDTH-1:0]);
   endfunction

   function automatic logic signed [W_WIDTH-1:0] sat_w(input logic signed [DIFF_WIDTH-1:0] s);
      if (s > 24'sd127)
         return 8'h7F;
      else if (s < -24'sd128)
         return 8'h80;
      else
         return $signed(s[W_WIDTH-1:0]);
   endfunction

endpackage

// File: rtl/output_weight_update_if.sv
// Bus between the training controller and the output-weight update stage.
// The master drives target, result and activations; the slave returns weights and status.
interface output_weight_update_if;
   import idann_pkg::*;

   logic                       start_i;
   logic [T_WIDTH-1:0]         target_i;
   logic [Y_WIDTH-1:0]         y_i;
   logic [N_HID*X_WIDTH-1:0]   x_i;
   logic [N_HID*W_WIDTH-1:0]   w_o;
   logic                       busy_o;
   logic                       done_o;
   logic [IDX_WIDTH-1:0]       idx_o;

   modport master (
      output start_i, target_i, y_i, x_i,
      input  w_o, busy_o, done_o, idx_o
   );

   modport slave (
      input  start_i, target_i, y_i, x_i,
      output w_o, busy_o, done_o, idx_o
   );

endinterface

// File: rtl/output_weight_update_weight_step.sv
// Combinational single-weight step: w_new = sat_w(w + ((err * x) >>> LR_SHIFT)).
// Zero latency; no flow control.
module weight_step
   import idann_pkg::*;
(
   input  logic signed [W_WIDTH-1:0]   w,
   input  logic signed [ERR_WIDTH-1:0] err,
   input  logic        [X_WIDTH-1:0]   x,
   output logic signed [W_WIDTH-1:0]   w_new
);

   localparam int P_WIDTH = ERR_WIDTH + X_WIDTH + 1;

   logic signed [P_WIDTH-1:0]    err_ext;
   logic signed [P_WIDTH-1:0]    x_ext;
   logic signed [P_WIDTH-1:0]    prod;
   logic signed [P_WIDTH-1:0]    delta;
   logic signed [DIFF_WIDTH-1:0] sum;

   // x is unsigned, so it gets a zero sign bit before the signed multiply
   assign err_ext = {{(P_WIDTH-ERR_WIDTH){err[ERR_WIDTH-1]}}, err};
   assign x_ext   = {{(P_WIDTH-X_WIDTH){1'b0}}, x};
   assign prod    = err_ext * x_ext;
   assign delta   = prod >>> LR_SHIFT;
   assign sum     = {{(DIFF_WIDTH-W_WIDTH){w[W_WIDTH-1]}}, w}
                  + {{(DIFF_WIDTH-P_WIDTH){delta[P_WIDTH-1]}}, delta};
   assign w_new   = sat_w(sum);

endmodule

// File: rtl/output_weight_update.sv
// Output-layer weight update: captures error and activations on start, then updates one weight per cycle.
// Start-to-done takes 10 cycles; en_i low freezes everything and start_i is ignored while busy.
module output_weight_update
   import idann_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   output_weight_update_if.slave bus
);

   state_t                      state_q, state_d;
   logic [IDX_WIDTH-1:0]        k_q;
   logic signed [ERR_WIDTH-1:0] err_q;
   logic [X_WIDTH-1:0]          x_q [N_HID];
   logic signed [W_WIDTH-1:0]   w_q [N_HID];
   logic signed [W_WIDTH-1:0]   w_new;
   logic signed [DIFF_WIDTH-1:0] diff;
   logic                        busy, done;
   logic [IDX_WIDTH-1:0]        idx;

   assign diff = {{(DIFF_WIDTH-T_WIDTH){1'b0}}, bus.target_i}
               - {{(DIFF_WIDTH-Y_WIDTH){1'b0}}, bus.y_i};

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_q <= IDLE;
      else if (en_i)
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start_i) state_d = CAPTURE;
         CAPTURE: state_d = UPDATE;
         UPDATE:  if (k_q == IDX_WIDTH'(N_HID-1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      idx  = '0;
      case (state_q)
         CAPTURE: busy = 1'b1;
         UPDATE: begin
            busy = 1'b1;
            idx  = k_q;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   weight_step u_step (
      .w     (w_q[k_q]),
      .err   (err_q),
      .x     (x_q[k_q]),
      .w_new (w_new)
   );

   // k wraps back to 0 after the last weight, ready for the next pass
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         k_q   <= '0;
         err_q <= '0;
         for (int i = 0; i < N_HID; i++) begin
            x_q[i] <= '0;
            w_q[i] <= $signed(INIT_OW[i*W_WIDTH +: W_WIDTH]);
         end
      end else if (en_i) begin
         case (state_q)
            CAPTURE: begin
               k_q   <= '0;
               err_q <= sat_err(diff);
               for (int i = 0; i < N_HID; i++)
                  x_q[i] <= bus.x_i[i*X_WIDTH +: X_WIDTH];
            end
            UPDATE: begin
               w_q[k_q] <= w_new;
               k_q      <= k_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < N_HID; g++) begin : g_wout
      assign bus.w_o[g*W_WIDTH +: W_WIDTH] = w_q[g];
   end

   assign bus.busy_o = busy;
   assign bus.done_o = done;
   assign bus.idx_o  = idx;

endmodule

// File: tb/tb_output_weight_update.sv
// Directed bench: each pass pushes its predicted weight vector to a scoreboard,
// popped and compared when done_o appears; timing, hold and abort are checked inline.
module tb_output_weight_update;
   import idann_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic en;

   always #5 clk = ~clk;

   output_weight_update_if bus();

   output_weight_update dut (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (en),
      .bus   (bus)
   );

   int total  = 0;
   int passed = 0;
   int fails  = 0;
   int mw [N_HID];
   logic [N_HID*W_WIDTH-1:0] sb_q [$];

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int wgt(input int k);
      logic [W_WIDTH-1:0] b;
      b = bus.w_o[k*W_WIDTH +: W_WIDTH];
      return int'($signed(b));
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // floor(p / 16), written as a division rather than a shift
   function automatic int fdiv16(input int p);
      if (p >= 0) return p / 16;
      return -((-p + 15) / 16);
   endfunction

   task automatic drive_inputs(input int tgt, input int yv, input int xv);
      bus.target_i = T_WIDTH'(tgt);
      bus.y_i      = Y_WIDTH'(yv);
      for (int i = 0; i < N_HID; i++)
         bus.x_i[i*X_WIDTH +: X_WIDTH] = X_WIDTH'(xv);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < N_HID; k++) mw[k] = k + 1;
   endtask

   task automatic run_pass(input int tgt, input int yv, input int xv,
                           input int hold_n, input bit poke);
      int err;
      int n;
      int busy_cnt;
      int idx_err;
      logic [N_HID*W_WIDTH-1:0] e;
      logic [W_WIDTH-1:0] eb;
      err = clamp(tgt - yv, -2048, 2047);
      for (int k = 0; k < N_HID; k++) begin
         mw[k] = clamp(mw[k] + fdiv16(err * xv), -128, 127);
         e[k*W_WIDTH +: W_WIDTH] = W_WIDTH'(mw[k]);
      end
      sb_q.push_back(e);

      drive_inputs(tgt, yv, xv);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      n = 1;
      busy_cnt = 0;
      idx_err = 0;
      while (n <= 40 && !bus.done_o) begin
         if (bus.busy_o) busy_cnt++;
         if (hold_n == 0 && n >= 2 && n <= 9 && bus.idx_o != IDX_WIDTH'(n - 2)) idx_err++;
         bus.start_i = (poke && n == 4);
         if (hold_n > 0 && n == 5) begin
            check("hold_idx_enter", int'(bus.idx_o), 3);
            en = 1'b0;
            for (int h = 0; h < hold_n; h++) begin
               @(negedge clk);
               n++;
               if (bus.busy_o) busy_cnt++;
               check("hold_idx", int'(bus.idx_o), 3);
            end
            en = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      bus.start_i = 1'b0;
      check("done_latency", n, 10 + hold_n);
      check("done_high", int'(bus.done_o), 1);
      check("busy_at_done", int'(bus.busy_o), 0);
      check("busy_cycles", busy_cnt, 9 + hold_n);
      if (hold_n == 0) check("idx_sequence_errors", idx_err, 0);

      check("sb_nonempty", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         for (int k = 0; k < N_HID; k++) begin
            eb = e[k*W_WIDTH +: W_WIDTH];
            check($sformatf("w%0d", k), wgt(k), int'($signed(eb)));
         end
      end

      @(negedge clk);
      check("done_one_pulse", int'(bus.done_o), 0);
      check("idle_after_done", int'(bus.busy_o), 0);
   endtask

   initial begin
      int done_cnt;
      rst = 1'b1;
      en  = 1'b1;
      bus.start_i = 1'b0;
      drive_inputs(0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < N_HID; k++) mw[k] = k + 1;

      check("rst_busy", int'(bus.busy_o), 0);
      check("rst_done", int'(bus.done_o), 0);
      check("rst_idx", int'(bus.idx_o), 0);
      for (int k = 0; k < N_HID; k++) check($sformatf("rst_w%0d", k), wgt(k), k + 1);

      // zero error keeps weights
      run_pass(50, 50, 1, 0, 1'b0);
      // err=64, x=2 -> +8 each
      run_pass(100, 36, 2, 0, 1'b0);
      // err=-1 rounds to delta=-1, then err=-16 also -1
      do_reset();
      run_pass(0, 1, 1, 0, 1'b0);
      run_pass(0, 16, 1, 0, 1'b0);
      // positive saturation, with a start pulse while busy
      run_pass(1023, 0, 1023, 0, 1'b1);
      // negative error clamp and weight floor
      run_pass(0, 5000000, 1023, 0, 1'b0);
      // enable held low for three cycles at k=3
      run_pass(1023, 0, 1, 3, 1'b0);

      // reset at k=5 aborts without done
      drive_inputs(1023, 0, 1);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_idx", int'(bus.idx_o), 5);
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < N_HID; k++) check($sformatf("abort_w%0d", k), wgt(k), k + 1);
      check("abort_busy", int'(bus.busy_o), 0);
      check("abort_idx_zero", int'(bus.idx_o), 0);
      rst = 1'b0;
      for (int k = 0; k < N_HID; k++) mw[k] = k + 1;
      done_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done_o) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);

      run_pass(50, 50, 3, 0, 1'b0);
      check("sb_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
